// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state type and latency defaults for alu_arbiter
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    localparam int DEFAULT_MUL_CYCLES = 2;
    localparam int DEFAULT_DIV_CYCLES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Counter preload: the number of EXEC cycles minus one.
    function automatic logic [3:0] op_count(input logic [2:0] op,
                                            input int mul_cycles,
                                            input int div_cycles);
        case (op)
            OP_MUL:  return 4'(mul_cycles - 1);
            OP_DIV:  return 4'(div_cycles - 1);
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 16-bit ALU datapath with error flag
module alu
    import alu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        err
);

    always_comb begin
        result = 32'h0;
        err    = 1'b0;
        case (op)
            OP_AND: result = {16'h0, a & b};
            OP_OR:  result = {16'h0, a | b};
            OP_ADD: result = {16'h0, a} + {16'h0, b};
            OP_SUB: result = {16'h0, a} - {16'h0, b};
            OP_MUL: result = {16'h0, a} * {16'h0, b};
            OP_DIV: begin
                // Divide-by-zero forces a clean zero result instead of divider output.
                if (b == 16'h0) begin
                    err = 1'b1;
                end else begin
                    result = {a % b, a / b};
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester ALU arbiter; ALU_ARB_ROUND_ROBIN_EN selects round-robin grant
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic        busy
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  count;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [2:0]  op_q;
    logic        id_q;
    logic        grant_id;
    logic        handshake;
    logic [31:0] alu_result;
    logic        alu_err;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (handshake) begin
            last_grant <= grant_id;
        end
    end
`else
    always_comb begin
        grant_id = 1'b0;
        grant_id = req1_valid && !req0_valid;
    end
`endif

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req0_ready = rst_n && (state == ST_IDLE) && req0_valid && !grant_id;
    assign req1_ready = rst_n && (state == ST_IDLE) && req1_valid &&  grant_id;
    assign handshake  = req0_ready || req1_ready;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (handshake)      state_nxt = ST_EXEC;
            ST_EXEC: if (count == 4'd0)  state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 4'd0;
            a_q        <= 16'h0;
            b_q        <= 16'h0;
            op_q       <= 3'b000;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (handshake) begin
                    a_q   <= grant_id ? req1_a  : req0_a;
                    b_q   <= grant_id ? req1_b  : req0_b;
                    op_q  <= grant_id ? req1_op : req0_op;
                    id_q  <= grant_id;
                    count <= op_count(grant_id ? req1_op : req0_op, MUL_CYCLES, DIV_CYCLES);
                end
            end else if (count == 4'd0) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= id_q;
                rsp_result <= alu_result;
                rsp_err    <= alu_err;
            end else begin
                count <= count - 4'd1;
            end
        end
    end

    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .err    (alu_err)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (honours ALU_ARB_ROUND_ROBIN_EN)
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result;

    typedef struct {
        bit          id;
        logic [31:0] res;
        bit          err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   hs_all[$];
    bit   gid_log[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   w0, w1, nbusy;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: logs handshakes and checks every response against the scoreboard.
    initial forever begin
        @(negedge clk);
        #2;
        cyc++;
        if (req0_valid && req0_ready) begin
            gid_log.push_back(1'b0); hs_cyc.push_back(cyc); hs_all.push_back(cyc);
        end
        if (req1_valid && req1_ready) begin
            gid_log.push_back(1'b1); hs_cyc.push_back(cyc); hs_all.push_back(cyc);
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0 || hs_cyc.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                int   h;
                e = exp_q.pop_front();
                h = hs_cyc.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(cyc - h), 32'(e.lat + 1));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic drive(input bit port, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] res, input bit err,
                         input int lat, input bit push, input bit hold, output int waited);
        bit done;
        done   = 1'b0;
        waited = 0;
        if (!port) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (port ? req1_ready : req0_ready) begin
                if (push) exp_q.push_back('{port, res, err, lat});
                done = 1'b1;
            end else begin
                waited++;
                @(negedge clk);
            end
        end
        if (!done) chk("handshake_timeout", 32'(done), 32'd1);
        @(negedge clk);
        if (!hold) begin
            if (!port) req0_valid = 1'b0;
            else       req1_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #3;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        drive(1'b0, OP_ADD, 16'd5, 16'd7, 32'd12, 1'b0, 1, 1'b1, 1'b0, w0);
        chk("add_ready_first_cycle", 32'(w0), 32'd0);
        wait_drain();

        drive(1'b1, OP_DIV, 16'd17, 16'd5, 32'h0002_0003, 1'b0, 4, 1'b1, 1'b0, w0);
        nbusy = 0;
        for (int k = 0; k < 8; k++) begin
            // A valid pulse during EXEC must be dropped silently.
            if (k == 0) begin req0_valid = 1'b1; req0_op = OP_ADD; end
            if (k == 1) req0_valid = 1'b0;
            #1;
            if (busy) nbusy++;
            @(negedge clk);
        end
        chk("div_busy_cycles", 32'(nbusy), 32'd4);
        wait_drain();

        drive(1'b0, OP_DIV, 16'd9, 16'd0, 32'h0, 1'b1, 4, 1'b1, 1'b0, w0);
        drive(1'b0, 3'b111, 16'd9, 16'd3, 32'h0, 1'b1, 1, 1'b1, 1'b0, w0);
        drive(1'b1, 3'b110, 16'd1, 16'd1, 32'h0, 1'b1, 1, 1'b1, 1'b0, w0);
        drive(1'b1, OP_SUB, 16'd10, 16'd3, 32'd7, 1'b0, 1, 1'b1, 1'b0, w0);
        drive(1'b1, OP_AND, 16'hF0F0, 16'h3CFF, 32'h0000_30F0, 1'b0, 1, 1'b1, 1'b0, w0);
        drive(1'b0, OP_MUL, 16'd300, 16'd400, 32'h0001_D4C0, 1'b0, 2, 1'b1, 1'b0, w0);
        wait_drain();

        drive(1'b1, OP_MUL, 16'hFFFF, 16'd2, 32'h0, 1'b0, 2, 1'b0, 1'b0, w0);
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = OP_OR; req0_a = 16'h00F0; req0_b = 16'h0F00;
        #1;
        hs_cyc.delete();
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_result", rsp_result, 32'h0);
        chk("abort_rsp_err", 32'(rsp_err), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req0_ready", 32'(req0_ready), 32'd0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, OP_OR, 16'h00F0, 16'h0F00, 32'h0000_0FF0, 1'b0, 1, 1'b1, 1'b0, w0);
        chk("or_after_abort_ready", 32'(w0), 32'd0);
        wait_drain();

        apply_reset();
        @(negedge clk);
        gid_log.delete();
        fork
            for (int i = 0; i < 4; i++)
                drive(1'b0, OP_ADD, 16'(i), 16'd1, 32'(i + 1), 1'b0, 1, 1'b1, i < 3, w0);
            for (int j = 0; j < 4; j++)
                drive(1'b1, OP_ADD, 16'(100 + j), 16'(j), 32'(100 + 2 * j), 1'b0, 1, 1'b1, j < 3, w1);
        join
        wait_drain();
        chk("grant_count", 32'(gid_log.size()), 32'd8);
        if (gid_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                chk($sformatf("grant_order_%0d", k), 32'(gid_log[k]), 32'(k % 2));
`else
                chk($sformatf("grant_order_%0d", k), 32'(gid_log[k]), 32'(k >= 4));
`endif
            end
        end

        hs_all.delete();
        for (int i = 0; i < 4; i++)
            drive(1'b0, OP_ADD, 16'(1000 * i), 16'd33, 32'(1000 * i + 33), 1'b0, 1, 1'b1, i < 3, w0);
        wait_drain();
        chk("b2b_handshakes", 32'(hs_all.size()), 32'd4);
        if (hs_all.size() == 4) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("b2b_spacing_%0d", k), 32'(hs_all[k + 1] - hs_all[k]), 32'd2);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
